jtframe_sdram_bank_sched: RTL and testbench
===========================================

Name: jtframe_sdram_bank_sched

Overview:
- Schedules the SDRAM command engine among four game bank ports (ba0..ba3), the ROM-download (prog) port and periodic refresh.
- Sits between the game's bank request signals and the single-transaction SDRAM command engine inside the frame.
- Grants one transaction at a time, latches its address and data, and routes ack/dst/dok/rdy back to the granted requester only.

Parameters:
AW, 22, SDRAM word address width (23 for large SDRAM).
RFSH_EN, 1, 1 = issue periodic refresh; 0 = never request refresh.
RFSH_CYCLES, 1536, clk cycles between refresh requests (must be ≥ 2).

Ports:
clk  in  1  system clock (single clock domain)
rst  in  1  asynchronous, active-high reset
downloading  in  1  1 = only prog and refresh are served
prog_rd, prog_we  in  1  prog read / write request, level, held until prog_ack
prog_addr  in  AW  prog word address
prog_ba  in  2  prog bank
prog_din  in  16  prog write data
prog_dsn  in  2  prog byte mask, active low
prog_ack, prog_dst, prog_dok, prog_rdy  out  1  prog handshake returns
ba_rd, ba_wr  in  4  per-bank read / write request, level, held until ba_ack
ba_addr  in  4*AW  bank addresses, bank n at [n*AW +: AW]
ba_din  in  64  write data, bank n at [n*16 +: 16]
ba_dsn  in  8  byte masks, bank n at [n*2 +: 2]
ba_ack, ba_dst, ba_dok, ba_rdy  out  4  per-bank handshake returns
cmd_req  out  1  command request to engine
cmd_wr  out  1  1 = write, 0 = read
cmd_ba  out  2  bank
cmd_addr  out  AW  address
cmd_din  out  16  write data
cmd_dsn  out  2  byte mask
cmd_ack, cmd_dst, cmd_dok, cmd_rdy  in  1  engine: accepted, data start, data valid, done
rfsh_req  out  1  refresh request to engine
rfsh_done  in  1  refresh completed pulse

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; round-robin pointer=0; refresh counter=RFSH_CYCLES-1; rfsh_pend=0.
  - All outputs 0, except cmd_dsn=2'b11.
  - Reset mid-transaction abandons the grant; no ack/rdy is emitted afterwards.
- FSM states:
  - IDLE: evaluates requests every cycle. The winner is registered: request at cycle N gives cmd_req=1 at N+1 with cmd_* latched, state ISSUE.
  - ISSUE: cmd_req held until cmd_ack=1. In that same cycle the winner's *_ack pulses for 1 cycle, cmd_req drops next cycle, state BUSY.
  - BUSY: cmd_dst/cmd_dok/cmd_rdy are routed combinationally to the granted requester's dst/dok/rdy; all other requesters see 0. After cmd_rdy, state IDLE next cycle.
  - RFSH: rfsh_req=1 until rfsh_done, then rfsh_pend clears, rfsh_req drops next cycle, state IDLE.
- Priority in IDLE:
  1. rfsh_pend.
  2. prog, only when downloading=1.
  3. Game banks, only when downloading=0.
- Round-robin across banks:
  - Search starts at the pointer; first bank with rd|wr wins.
  - On grant, pointer = granted bank + 1 mod 4.
  - If rd and wr are both set on one bank, the write is taken.
- Prog: if prog_we and prog_rd are both set, the write is taken. cmd_ba=prog_ba. Game ba_* outputs stay 0 while downloading.
- Refresh counter:
  - Decrements every cycle; at 0 it reloads RFSH_CYCLES-1 and sets rfsh_pend (if RFSH_EN).
  - Further expiries while pending are dropped (no queueing).
  - Refresh never preempts an active transaction; it waits for IDLE.
- Requesters must deassert after *_ack or *_rdy. A request still high when IDLE is re-entered competes again with the rotated pointer.
- downloading toggling mid-transaction does not abort the transaction; it only affects the next arbitration.
- Latency, uncontended read: request to cmd_req is 1 cycle; total latency is 1 + engine latency + 1 idle cycle.

Test Plan:
- Reset, then ba_rd=4'b0001, addr=0x12345 -> cmd_req at +1 cycle with cmd_addr=0x12345, cmd_ba=0, cmd_wr=0; cmd_ack -> ba_ack=4'b0001 for 1 cycle; cmd_rdy -> ba_rdy[0] only.
- ba_rd=4'b1111 held, engine answers instantly each time -> grant order 0,1,2,3,0; no bank skipped or granted twice in a row.
- downloading=1, prog_we=1 with ba_rd=4'b0010 also high -> only the prog is served: cmd_wr=1, cmd_din=prog_din, cmd_ba=prog_ba, prog_ack pulses; ba_ack stays 0.
- RFSH_CYCLES=16, bank busy across the expiry -> rfsh_req rises only after the next return to IDLE, before any pending bank; rfsh_done clears it; a second expiry while pending yields only one refresh.
- Assert rst during BUSY, then pulse cmd_rdy -> no ba_rdy; state IDLE, pointer 0, cmd_req 0, counter reloaded.
- ba_rd[2]=1 and ba_wr[2]=1 simultaneously -> cmd_wr=1, cmd_din=ba_din[47:32], cmd_dsn=ba_dsn[5:4].

Source files
------------

// File: rtl/jtframe_sdram_bank_sched.sv
// jtframe_sdram_bank_sched
//   Arbitrates the single-transaction SDRAM command engine among four game
//   bank ports, the ROM-download (prog) port and periodic refresh. One
//   transaction is granted at a time; its address/data are latched onto
//   cmd_* and the engine's ack/dst/dok/rdy are routed back to the granted
//   requester only.
//
// Ports
//   clk, rst                 system clock, asynchronous active-high reset
//   downloading              1 = only prog and refresh are served
//   prog_*                   download port request/handshake
//   ba_rd/ba_wr/ba_addr/...  four game bank ports, bank n in slice n
//   ba_ack/dst/dok/rdy       per-bank handshake returns
//   cmd_*                    command to / handshake from the SDRAM engine
//   rfsh_req, rfsh_done      refresh request to engine / completion pulse
module jtframe_sdram_bank_sched #(
    parameter int AW          = 22,
    parameter int RFSH_EN     = 1,
    parameter int RFSH_CYCLES = 1536
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            downloading,
    // download port
    input  logic            prog_rd,
    input  logic            prog_we,
    input  logic [AW-1:0]   prog_addr,
    input  logic [1:0]      prog_ba,
    input  logic [15:0]     prog_din,
    input  logic [1:0]      prog_dsn,
    output logic            prog_ack,
    output logic            prog_dst,
    output logic            prog_dok,
    output logic            prog_rdy,
    // game bank ports
    input  logic [3:0]      ba_rd,
    input  logic [3:0]      ba_wr,
    input  logic [4*AW-1:0] ba_addr,
    input  logic [63:0]     ba_din,
    input  logic [7:0]      ba_dsn,
    output logic [3:0]      ba_ack,
    output logic [3:0]      ba_dst,
    output logic [3:0]      ba_dok,
    output logic [3:0]      ba_rdy,
    // command engine
    output logic            cmd_req,
    output logic            cmd_wr,
    output logic [1:0]      cmd_ba,
    output logic [AW-1:0]   cmd_addr,
    output logic [15:0]     cmd_din,
    output logic [1:0]      cmd_dsn,
    input  logic            cmd_ack,
    input  logic            cmd_dst,
    input  logic            cmd_dok,
    input  logic            cmd_rdy,
    output logic            rfsh_req,
    input  logic            rfsh_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;
    localparam logic [1:0] S_RFSH  = 2'd3;

    localparam int CW = (RFSH_CYCLES > 2) ? $clog2(RFSH_CYCLES) : 1;
    localparam logic [CW-1:0] RFSH_RELOAD = CW'(RFSH_CYCLES - 1);

    logic [1:0]    state;
    logic [1:0]    rr_ptr;
    logic [CW-1:0] rfsh_cnt;
    logic          rfsh_pend;
    logic          sel_prog;
    logic [1:0]    sel_bank;

    logic [3:0]    ba_req;
    logic [1:0]    pick;
    logic [1:0]    idx;
    logic          found;
    logic          issue_ack;
    logic          busy;

    assign ba_req = ba_rd | ba_wr;

    // Rotating search starting at rr_ptr; first requesting bank wins.
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = rr_ptr + 2'(i);
            if (!found && ba_req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            rfsh_cnt  <= RFSH_RELOAD;
            rfsh_pend <= 1'b0;
            sel_prog  <= 1'b0;
            sel_bank  <= '0;
            cmd_req   <= 1'b0;
            cmd_wr    <= 1'b0;
            cmd_ba    <= '0;
            cmd_addr  <= '0;
            cmd_din   <= '0;
            cmd_dsn   <= '1;
            rfsh_req  <= 1'b0;
        end else begin
            // Expiries while already pending collapse into the one request.
            if (rfsh_cnt == '0) begin
                rfsh_cnt <= RFSH_RELOAD;
                if (RFSH_EN != 0) rfsh_pend <= 1'b1;
            end else begin
                rfsh_cnt <= rfsh_cnt - 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (rfsh_pend) begin
                        state    <= S_RFSH;
                        rfsh_req <= 1'b1;
                    end else if (downloading && (prog_rd || prog_we)) begin
                        state    <= S_ISSUE;
                        cmd_req  <= 1'b1;
                        sel_prog <= 1'b1;
                        cmd_wr   <= prog_we;
                        cmd_ba   <= prog_ba;
                        cmd_addr <= prog_addr;
                        cmd_din  <= prog_din;
                        cmd_dsn  <= prog_dsn;
                    end else if (!downloading && found) begin
                        state    <= S_ISSUE;
                        cmd_req  <= 1'b1;
                        sel_prog <= 1'b0;
                        sel_bank <= pick;
                        cmd_wr   <= ba_wr[pick];
                        cmd_ba   <= pick;
                        cmd_addr <= ba_addr[pick*AW +: AW];
                        cmd_din  <= ba_din[pick*16 +: 16];
                        cmd_dsn  <= ba_dsn[pick*2 +: 2];
                        rr_ptr   <= pick + 2'd1;
                    end
                end
                S_ISSUE: begin
                    if (cmd_ack) begin
                        cmd_req <= 1'b0;
                        state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cmd_rdy) state <= S_IDLE;
                end
                S_RFSH: begin
                    // Clearing here overrides a same-cycle expiry above.
                    if (rfsh_done) begin
                        rfsh_req  <= 1'b0;
                        rfsh_pend <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign issue_ack = (state == S_ISSUE) && cmd_ack;
    assign busy      = (state == S_BUSY);

    // Engine handshakes reach only the granted requester.
    always_comb begin
        prog_ack = issue_ack & sel_prog;
        prog_dst = busy & sel_prog & cmd_dst;
        prog_dok = busy & sel_prog & cmd_dok;
        prog_rdy = busy & sel_prog & cmd_rdy;
        ba_ack   = '0;
        ba_dst   = '0;
        ba_dok   = '0;
        ba_rdy   = '0;
        if (!sel_prog) begin
            ba_ack[sel_bank] = issue_ack;
            ba_dst[sel_bank] = busy & cmd_dst;
            ba_dok[sel_bank] = busy & cmd_dok;
            ba_rdy[sel_bank] = busy & cmd_rdy;
        end
    end

endmodule

// File: tb/tb_jtframe_sdram_bank_sched.sv
// Directed bench for jtframe_sdram_bank_sched with a short refresh period.
module tb_jtframe_sdram_bank_sched;

    localparam int AW = 22;

    logic            clk = 1'b0;
    logic            rst;
    logic            downloading;
    logic            prog_rd, prog_we;
    logic [AW-1:0]   prog_addr;
    logic [1:0]      prog_ba;
    logic [15:0]     prog_din;
    logic [1:0]      prog_dsn;
    logic            prog_ack, prog_dst, prog_dok, prog_rdy;
    logic [3:0]      ba_rd, ba_wr;
    logic [4*AW-1:0] ba_addr;
    logic [63:0]     ba_din;
    logic [7:0]      ba_dsn;
    logic [3:0]      ba_ack, ba_dst, ba_dok, ba_rdy;
    logic            cmd_req, cmd_wr;
    logic [1:0]      cmd_ba;
    logic [AW-1:0]   cmd_addr;
    logic [15:0]     cmd_din;
    logic [1:0]      cmd_dsn;
    logic            cmd_ack, cmd_dst, cmd_dok, cmd_rdy;
    logic            rfsh_req, rfsh_done;

    int passes = 0;
    int total  = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    jtframe_sdram_bank_sched #(
        .AW(AW), .RFSH_EN(1), .RFSH_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .downloading(downloading),
        .prog_rd(prog_rd), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_ba(prog_ba), .prog_din(prog_din), .prog_dsn(prog_dsn),
        .prog_ack(prog_ack), .prog_dst(prog_dst), .prog_dok(prog_dok),
        .prog_rdy(prog_rdy),
        .ba_rd(ba_rd), .ba_wr(ba_wr), .ba_addr(ba_addr), .ba_din(ba_din),
        .ba_dsn(ba_dsn), .ba_ack(ba_ack), .ba_dst(ba_dst), .ba_dok(ba_dok),
        .ba_rdy(ba_rdy),
        .cmd_req(cmd_req), .cmd_wr(cmd_wr), .cmd_ba(cmd_ba),
        .cmd_addr(cmd_addr), .cmd_din(cmd_din), .cmd_dsn(cmd_dsn),
        .cmd_ack(cmd_ack), .cmd_dst(cmd_dst), .cmd_dok(cmd_dok),
        .cmd_rdy(cmd_rdy),
        .rfsh_req(rfsh_req), .rfsh_done(rfsh_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (failure #%0d)", tag, obs, exp, fails);
        end
    endtask

    // Inputs change and outputs are sampled 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        downloading = 0; prog_rd = 0; prog_we = 0; prog_addr = '0; prog_ba = '0;
        prog_din = '0; prog_dsn = '1; ba_rd = '0; ba_wr = '0; ba_addr = '0;
        ba_din = '0; ba_dsn = '1; cmd_ack = 0; cmd_dst = 0; cmd_dok = 0;
        cmd_rdy = 0; rfsh_done = 0;
    endtask

    // Releases reset 2 units after an edge; the next edge is cycle 1.
    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    function automatic int enc(input logic [3:0] a);
        case (a)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return -1;
        endcase
    endfunction

    // Waits (bounded) for a grant, answers it instantly, returns granted bank.
    task automatic serve(output int got);
        int n;
        n = 0;
        got = -1;
        while (cmd_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("serve_wait_cycles_ok", 32'(n < 20), 32'd1);
        if (cmd_req === 1'b1) begin
            cmd_ack = 1;
            #1;
            got = enc(ba_ack);
            tick();
            cmd_ack = 0;
            cmd_rdy = 1;
            tick();
            cmd_rdy = 0;
        end
    endtask

    initial begin
        int got;
        rst = 1;
        clear_inputs();

        // ---------------- reset state + single read on bank 0
        do_reset();
        chk("rst_cmd_req", 32'(cmd_req), 32'd0);
        chk("rst_cmd_dsn", 32'(cmd_dsn), 32'h3);
        chk("rst_rfsh_req", 32'(rfsh_req), 32'd0);
        chk("rst_ba_ack", 32'(ba_ack), 32'd0);
        chk("rst_prog_ack", 32'(prog_ack), 32'd0);
        ba_rd = 4'b0001;
        ba_addr[0*AW +: AW] = 22'h12345;
        ba_addr[1*AW +: AW] = 22'h0AAAA;
        tick();
        chk("rd_cmd_req", 32'(cmd_req), 32'd1);
        chk("rd_cmd_addr", 32'(cmd_addr), 32'h12345);
        chk("rd_cmd_ba", 32'(cmd_ba), 32'd0);
        chk("rd_cmd_wr", 32'(cmd_wr), 32'd0);
        chk("rd_ack_before", 32'(ba_ack), 32'd0);
        cmd_ack = 1;
        #1;
        chk("rd_ba_ack", 32'(ba_ack), 32'b0001);
        chk("rd_prog_ack", 32'(prog_ack), 32'd0);
        tick();
        cmd_ack = 0;
        ba_rd = '0;
        chk("rd_req_dropped", 32'(cmd_req), 32'd0);
        chk("rd_ack_pulse", 32'(ba_ack), 32'd0);
        cmd_dst = 1;
        cmd_dok = 1;
        #1;
        chk("rd_ba_dst", 32'(ba_dst), 32'b0001);
        chk("rd_ba_dok", 32'(ba_dok), 32'b0001);
        chk("rd_prog_dok", 32'(prog_dok), 32'd0);
        cmd_dst = 0;
        cmd_dok = 0;
        cmd_rdy = 1;
        #1;
        chk("rd_ba_rdy", 32'(ba_rdy), 32'b0001);
        tick();
        cmd_rdy = 0;
        #1;
        chk("rd_rdy_idle", 32'(ba_rdy), 32'd0);

        // ---------------- round robin with all banks requesting
        do_reset();
        ba_rd = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            serve(got);
            chk($sformatf("rr_grant_%0d", i), 32'(got), 32'(i % 4));
        end
        ba_rd = '0;
        tick();

        // ---------------- download: prog write wins over a game bank
        do_reset();
        downloading = 1;
        prog_we = 1;
        prog_rd = 1;
        prog_addr = 22'h2BCDE;
        prog_ba = 2'd3;
        prog_din = 16'hBEEF;
        prog_dsn = 2'b01;
        ba_rd = 4'b0010;
        ba_addr[1*AW +: AW] = 22'h00777;
        tick();
        chk("dl_cmd_req", 32'(cmd_req), 32'd1);
        chk("dl_cmd_wr", 32'(cmd_wr), 32'd1);
        chk("dl_cmd_din", 32'(cmd_din), 32'hBEEF);
        chk("dl_cmd_ba", 32'(cmd_ba), 32'd3);
        chk("dl_cmd_addr", 32'(cmd_addr), 32'h2BCDE);
        chk("dl_cmd_dsn", 32'(cmd_dsn), 32'b01);
        cmd_ack = 1;
        #1;
        chk("dl_prog_ack", 32'(prog_ack), 32'd1);
        chk("dl_ba_ack", 32'(ba_ack), 32'd0);
        tick();
        cmd_ack = 0;
        prog_we = 0;
        prog_rd = 0;
        cmd_rdy = 1;
        #1;
        chk("dl_prog_rdy", 32'(prog_rdy), 32'd1);
        chk("dl_ba_rdy", 32'(ba_rdy), 32'd0);
        tick();
        cmd_rdy = 0;
        tick();
        chk("dl_bank_ignored", 32'(cmd_req), 32'd0);
        chk("dl_bank_no_ack", 32'(ba_ack), 32'd0);

        // ---------------- read and write together on bank 2: write taken
        do_reset();
        ba_rd = 4'b0100;
        ba_wr = 4'b0100;
        ba_addr[2*AW +: AW] = 22'h3F00F;
        ba_din = 64'h1111_A5C3_2222_3333;
        ba_dsn = 8'b11_10_01_00;
        tick();
        chk("rw_cmd_wr", 32'(cmd_wr), 32'd1);
        chk("rw_cmd_din", 32'(cmd_din), 32'hA5C3);
        chk("rw_cmd_dsn", 32'(cmd_dsn), 32'b10);
        chk("rw_cmd_ba", 32'(cmd_ba), 32'd2);
        chk("rw_cmd_addr", 32'(cmd_addr), 32'h3F00F);
        cmd_ack = 1;
        tick();
        cmd_ack = 0;
        ba_rd = '0;
        ba_wr = '0;
        cmd_rdy = 1;
        tick();
        cmd_rdy = 0;

        // ---------------- refresh waits for IDLE, two expiries -> one refresh
        do_reset();
        ba_rd = 4'b0011;
        ba_addr[1*AW +: AW] = 22'h0BEEF;
        tick();                         // cycle 1: bank 0 granted
        cmd_ack = 1;
        tick();                         // cycle 2: BUSY
        cmd_ack = 0;
        ba_rd = 4'b0010;
        repeat (33) tick();             // cycle 35: expiries at 16 and 32 passed
        chk("rf_no_req_busy", 32'(rfsh_req), 32'd0);
        chk("rf_no_cmd_busy", 32'(cmd_req), 32'd0);
        cmd_rdy = 1;
        #1;
        chk("rf_ba_rdy", 32'(ba_rdy), 32'b0001);
        tick();                         // cycle 36: IDLE
        cmd_rdy = 0;
        chk("rf_idle_no_req", 32'(rfsh_req), 32'd0);
        tick();                         // cycle 37: refresh beats bank 1
        chk("rf_req_up", 32'(rfsh_req), 32'd1);
        chk("rf_bank_waits", 32'(cmd_req), 32'd0);
        rfsh_done = 1;
        tick();                         // cycle 38
        rfsh_done = 0;
        chk("rf_req_cleared", 32'(rfsh_req), 32'd0);
        tick();                         // cycle 39: bank 1, no second refresh
        chk("rf_single_refresh", 32'(rfsh_req), 32'd0);
        chk("rf_bank1_req", 32'(cmd_req), 32'd1);
        chk("rf_bank1_addr", 32'(cmd_addr), 32'h0BEEF);
        cmd_ack = 1;
        #1;
        chk("rf_bank1_ack", 32'(ba_ack), 32'b0010);
        tick();
        cmd_ack = 0;
        ba_rd = '0;
        cmd_rdy = 1;
        tick();
        cmd_rdy = 0;

        // ---------------- reset during BUSY abandons the grant
        do_reset();
        ba_rd = 4'b0100;
        tick();
        cmd_ack = 1;
        tick();                         // BUSY on bank 2, pointer now 3
        cmd_ack = 0;
        ba_rd = '0;
        rst = 1;
        #1;
        chk("rb_cmd_req", 32'(cmd_req), 32'd0);
        cmd_rdy = 1;
        cmd_dok = 1;
        #1;
        chk("rb_no_rdy", 32'(ba_rdy), 32'd0);
        chk("rb_no_dok", 32'(ba_dok), 32'd0);
        tick();
        cmd_rdy = 0;
        cmd_dok = 0;
        rst = 0;
        repeat (16) tick();
        chk("rb_cnt_not_yet", 32'(rfsh_req), 32'd0);
        tick();
        chk("rb_cnt_reloaded", 32'(rfsh_req), 32'd1);
        rfsh_done = 1;
        tick();
        rfsh_done = 0;
        ba_rd = 4'b1111;
        tick();
        chk("rb_ptr_zero_ba", 32'(cmd_ba), 32'd0);
        cmd_ack = 1;
        #1;
        chk("rb_ptr_zero_ack", 32'(ba_ack), 32'b0001);
        tick();
        cmd_ack = 0;
        ba_rd = '0;
        cmd_rdy = 1;
        tick();
        cmd_rdy = 0;
        tick();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
